// File: rtl/control_top_cpu8.sv
// Tiny Tapeout top of an 8-bit SAP-1 style accumulator CPU with a 16x8 unified RAM.
// The RAM is loaded over the pins in PROG mode. Each instruction takes 2 cycles (FETCH, EXEC).
module control_top_cpu8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt, StProg} state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] ir_q, ir_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic [7:0] out_q, out_d;
  logic [7:0] mem_q [16];

  logic       rst;
  logic       prog, we;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [8:0] sum;
  logic       upd_z;
  logic       unused_bits;

  assign rst         = ~rst_n;
  assign prog        = uio_in[4];
  assign we          = uio_in[5];
  assign unused_bits = ^{ena, uio_in[7:6]};

  // During EXEC the operand field addresses the RAM; otherwise the PC does.
  assign rd_addr = (state_q == StExec) ? ir_q[3:0] : pc_q;
  assign rd_data = mem_q[rd_addr];
  assign sum     = {1'b0, a_q} + {1'b0, rd_data};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    ir_d      = ir_q;
    c_d       = c_q;
    z_d       = z_q;
    out_d     = out_q;
    mem_we    = 1'b0;
    mem_waddr = 4'd0;
    mem_wdata = 8'd0;
    upd_z     = 1'b0;

    if (prog) begin
      state_d = StProg;
      pc_d    = 4'd0;
      a_d     = 8'd0;
      c_d     = 1'b0;
      z_d     = 1'b0;
      if (we) begin
        mem_we    = 1'b1;
        mem_waddr = uio_in[3:0];
        mem_wdata = ui_in;
      end
    end else begin
      unique case (state_q)
        // Leaving PROG behaves as a fetch so the first instruction starts at once.
        StFetch, StProg: begin
          ir_d    = rd_data;
          pc_d    = pc_q + 4'd1;
          state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          case (ir_q[7:4])
            4'h1: begin a_d = rd_data; upd_z = 1'b1; end
            4'h2: begin a_d = sum[7:0]; c_d = sum[8]; upd_z = 1'b1; end
            4'h3: begin a_d = a_q - rd_data; c_d = (a_q >= rd_data); upd_z = 1'b1; end
            4'h4: begin mem_we = 1'b1; mem_waddr = ir_q[3:0]; mem_wdata = a_q; end
            4'h5: begin a_d = {4'b0000, ir_q[3:0]}; upd_z = 1'b1; end
            4'h6: pc_d = ir_q[3:0];
            4'h7: if (c_q) pc_d = ir_q[3:0];
            4'h8: if (z_q) pc_d = ir_q[3:0];
            4'h9: begin a_d = a_q & rd_data; c_d = 1'b0; upd_z = 1'b1; end
            4'hA: begin a_d = a_q | rd_data; c_d = 1'b0; upd_z = 1'b1; end
            4'hB: begin a_d = a_q ^ rd_data; c_d = 1'b0; upd_z = 1'b1; end
            4'hC: begin a_d = ui_in; upd_z = 1'b1; end
            4'hD: out_d = a_q;
            4'hF: state_d = StHalt;
            default: ;
          endcase
          if (upd_z) z_d = (a_d == 8'd0);
        end
        StHalt: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= 4'd0;
      a_q     <= 8'd0;
      ir_q    <= 8'd0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'd0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign uo_out  = out_q;
  assign uio_out = {(state_q == StHalt), z_q, 6'b000000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_control_top_cpu8.sv
// Directed bench for control_top_cpu8: small hand-assembled programs with expected results
// observed on uo_out / uio_out at fixed cycle counts.
module tb_control_top_cpu8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  control_top_cpu8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    uio_in = 8'd0;
    ui_in  = 8'd0;
    step(2);
    rst_n = 1'b1;
  endtask

  // prog=1 (bit4), we=1 (bit5), address in [3:0]
  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    uio_in = {4'b0011, addr};
    ui_in  = data;
    step(1);
  endtask

  task automatic run(input logic [7:0] ui_val);
    uio_in = 8'd0;
    ui_in  = ui_val;
  endtask

  initial begin
    // Reset and free-running NOPs from the cleared RAM
    step(2);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hC0);
    rst_n = 1'b1;
    step(40);
    chk("nop_wrap_uo_out", uo_out, 8'h00);
    chk("nop_wrap_uio_out", uio_out, 8'h00);

    // LDI 5; ADD 14; OUT; HLT; M14=3
    do_reset();
    load(4'd0, 8'h55);
    load(4'd1, 8'h2E);
    load(4'd2, 8'hD0);
    load(4'd3, 8'hF0);
    load(4'd14, 8'h03);
    run(8'h00);
    step(7);
    chk("add_out_before_halt", uo_out, 8'h08);
    chk("add_not_yet_halted", uio_out, 8'h00);
    step(1);
    chk("add_out", uo_out, 8'h08);
    chk("add_halt_status", uio_out, 8'h80);
    step(5);
    chk("halt_holds_out", uo_out, 8'h08);
    chk("halt_holds_status", uio_out, 8'h80);

    // SUB/JC: LDI3; SUB13; JC9; OUT; LDI5; SUB12; JC8; HLT; OUT; HLT
    do_reset();
    load(4'd0, 8'h53);
    load(4'd1, 8'h3D);
    load(4'd2, 8'h79);
    load(4'd3, 8'hD0);
    load(4'd4, 8'h55);
    load(4'd5, 8'h3C);
    load(4'd6, 8'h78);
    load(4'd7, 8'hF0);
    load(4'd8, 8'hD0);
    load(4'd9, 8'hF0);
    load(4'd12, 8'h02);
    load(4'd13, 8'h05);
    run(8'h00);
    step(8);
    chk("sub_borrow_out", uo_out, 8'hFE);
    chk("sub_borrow_status", uio_out, 8'h00);
    step(10);
    chk("sub_jc_taken_out", uo_out, 8'h03);
    chk("sub_jc_taken_status", uio_out, 8'h80);

    // ADD overflow: LDA14; ADD13; JZ4; HLT; JC6; HLT; LDI9; OUT; HLT; M14=FF M13=01
    do_reset();
    load(4'd0, 8'h1E);
    load(4'd1, 8'h2D);
    load(4'd2, 8'h84);
    load(4'd3, 8'hF0);
    load(4'd4, 8'h76);
    load(4'd5, 8'hF0);
    load(4'd6, 8'h59);
    load(4'd7, 8'hD0);
    load(4'd8, 8'hF0);
    load(4'd13, 8'h01);
    load(4'd14, 8'hFF);
    run(8'h00);
    step(4);
    chk("ovf_zero_flag", uio_out, 8'h40);
    step(10);
    chk("ovf_jz_jc_out", uo_out, 8'h09);
    chk("ovf_final_status", uio_out, 8'h80);

    // STA/INP: INP; STA15; LDI0; LDA15; OUT; HLT with ui_in=A5
    do_reset();
    load(4'd0, 8'hC0);
    load(4'd1, 8'h4F);
    load(4'd2, 8'h50);
    load(4'd3, 8'h1F);
    load(4'd4, 8'hD0);
    load(4'd5, 8'hF0);
    run(8'hA5);
    step(6);
    chk("ldi0_sets_z", uio_out, 8'h40);
    step(6);
    chk("sta_inp_out", uo_out, 8'hA5);
    chk("sta_inp_status", uio_out, 8'h80);

    // Reset while halted clears regs and RAM; the program must not rerun
    rst_n = 1'b0;
    step(1);
    chk("midrst_uo_out", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    step(30);
    chk("midrst_ram_cleared", uo_out, 8'h00);
    chk("midrst_not_halted", uio_out, 8'h00);

    // prog while running: LDI7; OUT; JMP0 loop, then reprogram RAM0=LDI2
    do_reset();
    load(4'd0, 8'h57);
    load(4'd1, 8'hD0);
    load(4'd2, 8'h60);
    run(8'h00);
    step(10);
    chk("loop_out", uo_out, 8'h07);
    uio_in = 8'h10;
    step(2);
    chk("prog_holds_out", uo_out, 8'h07);
    chk("prog_status", uio_out, 8'h00);
    load(4'd0, 8'h52);
    run(8'h00);
    step(3);
    chk("reprog_out_pending", uo_out, 8'h07);
    step(1);
    chk("reprog_out_pc0", uo_out, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
